uart_report_tx: RTL and testbench

Transmit end of the demodulator status link to the host/display MCU. Snapshots the classified modulation type and demodulated frequency from the data selector, then frames them into a fixed 6-byte packet. Serialises the packet as UART 8N1 on a single tx pin. Sends periodically, and on demand via send_req.

---
 rtl/uart_report_tx_pkg.sv | 46 ++++
 rtl/uart_report_tx_if.sv | 26 ++
 rtl/uart_byte_tx.sv | 62 ++++++
 rtl/uart_report_tx.sv | 131 +++++++++++++
 tb/tb_uart_report_tx.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_report_tx_pkg.sv
// Package for the status-report UART link.
// Holds the frame constants, the modulation code values, the report FSM
// state type and the helpers that build the frame contents from a snapshot.
package uart_report_pkg;

  localparam logic [7:0] FRAME_HDR  = 8'hA5;
  localparam logic [7:0] FRAME_TAIL = 8'h5A;
  localparam int         FRAME_LEN  = 6;

  localparam logic [7:0] MOD_NONE = 8'd0;
  localparam logic [7:0] MOD_AM   = 8'd1;
  localparam logic [7:0] MOD_ASK  = 8'd2;
  localparam logic [7:0] MOD_FM   = 8'd3;
  localparam logic [7:0] MOD_FSK  = 8'd4;
  localparam logic [7:0] MOD_PSK  = 8'd5;
  localparam logic [7:0] MOD_CW   = 8'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } rpt_state_e;

  // No carrier and plain CW carry no meaningful frequency, so report zero.
  function automatic logic [15:0] report_freq(input logic [7:0] mod_type,
                                               input logic [15:0] demod_fre);
    return (mod_type == MOD_NONE || mod_type == MOD_CW) ? 16'h0000 : demod_fre;
  endfunction

  // Byte idx of a frame built from an already-masked snapshot.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [7:0]  mod_type,
                                            input logic [15:0] freq);
    logic [7:0] chk;
    chk = mod_type + freq[15:8] + freq[7:0];
    case (idx)
      3'd0:    return FRAME_HDR;
      3'd1:    return mod_type;
      3'd2:    return freq[15:8];
      3'd3:    return freq[7:0];
      3'd4:    return chk;
      default: return FRAME_TAIL;
    endcase
  endfunction

endpackage

// File: rtl/uart_report_tx_if.sv
// Status-report link bundle.
//   mod_type   : modulation code from the data selector
//   demod_fre  : demodulated frequency in Hz
//   send_req   : one-cycle pulse asking for an immediate report
//   tx         : UART line, idle high
//   busy       : high while a frame is on the line
//   frame_done : one-cycle pulse after the last stop bit
// master = the side that supplies the data and request, slave = the reporter.
interface uart_report_tx_if;
  logic [7:0]  mod_type;
  logic [15:0] demod_fre;
  logic        send_req;
  logic        tx;
  logic        busy;
  logic        frame_done;

  modport master (
    output mod_type, demod_fre, send_req,
    input  tx, busy, frame_done
  );

  modport slave (
    input  mod_type, demod_fre, send_req,
    output tx, busy, frame_done
  );
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   start, data        : byte offered for transmission
//   tx                 : serial line, idle high, registered
//   ready              : serialiser can take a byte this cycle
// Handshake: a byte is taken in a cycle where start && ready; start with
// ready low is ignored. ready is also high in the last cycle of a stop bit,
// so a byte offered then starts its start bit with no idle gap.
module uart_byte_tx #(
  parameter int BAUD_DIV = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int             CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);

  logic          active;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;   // 0 start, 1..8 data, 9 stop
  logic [7:0]    data_r;
  logic          bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign ready   = !active || (bit_end && bit_idx == 4'd9);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      data_r   <= '0;
      tx       <= 1'b1;
    end else if (start && ready) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      data_r   <= data;
      tx       <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          // Moving into slot bit_idx+1: data bits LSB first, then stop.
          tx      <= (bit_idx < 4'd8) ? data_r[bit_idx[2:0]] : 1'b1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_report_tx.sv
// Periodic / on-demand status reporter.
// Snapshots mod_type and demod_fre, frames them as
//   A5, mod, F[15:8], F[7:0], checksum, 5A
// and sends the frame as UART 8N1.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   rpt                : report link (slave side)
//   dbg_state          : current FSM state
module uart_report_tx
  import uart_report_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD          = 115200,
  parameter int REPORT_CYCLES = 5_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  uart_report_tx_if.slave  rpt,
  output rpt_state_e       dbg_state
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;

  logic tick;

  generate
    if (REPORT_CYCLES > 0) begin : g_timer
      localparam int            TW     = $clog2(REPORT_CYCLES + 1);
      localparam logic [TW-1:0] T_LAST = TW'(REPORT_CYCLES - 1);
      logic [TW-1:0] timer;

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)          timer <= '0;
        else if (timer == T_LAST) timer <= '0;
        else                      timer <= timer + 1'b1;
      end

      assign tick = (timer == T_LAST);
    end else begin : g_no_timer
      assign tick = 1'b0;
    end
  endgenerate

  rpt_state_e  state;
  logic        pending;
  logic        launch;
  logic [7:0]  snap_mod;
  logic [15:0] snap_f;
  logic [2:0]  byte_idx;      // next byte to hand to the serialiser
  logic        busy_r;
  logic        frame_done_r;

  logic        bt_start;
  logic [7:0]  bt_data;
  logic        bt_ready;
  logic        bt_tx;

  // DONE accepts a request just like IDLE, so back-to-back frames are
  // separated only by the single DONE cycle.
  assign launch = pending && (state == IDLE || state == DONE);

  // The header is constant, so it can be offered in the same cycle the
  // snapshot is taken; later bytes come from the snapshot.
  always_comb begin
    bt_start = 1'b0;
    bt_data  = FRAME_HDR;
    if (launch) begin
      bt_start = 1'b1;
    end else if (state == SEND && bt_ready && byte_idx != 3'(FRAME_LEN)) begin
      bt_start = 1'b1;
      bt_data  = frame_byte(byte_idx, snap_mod, snap_f);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      pending      <= 1'b0;
      snap_mod     <= '0;
      snap_f       <= '0;
      byte_idx     <= '0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      // A request arriving in the launch cycle survives, giving one follow-up.
      pending      <= (pending && !launch) || rpt.send_req || tick;
      frame_done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            snap_mod <= rpt.mod_type;
            snap_f   <= report_freq(rpt.mod_type, rpt.demod_fre);
            byte_idx <= 3'd1;
            busy_r   <= 1'b1;
            state    <= SEND;
          end else begin
            state <= IDLE;
          end
        end
        SEND: begin
          if (bt_ready) begin
            if (byte_idx == 3'(FRAME_LEN)) begin
              busy_r       <= 1'b0;
              frame_done_r <= 1'b1;
              state        <= DONE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_byte_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_byte_tx (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (bt_start),
    .data      (bt_data),
    .tx        (bt_tx),
    .ready     (bt_ready)
  );

  assign rpt.tx         = bt_tx;
  assign rpt.busy       = busy_r;
  assign rpt.frame_done = frame_done_r;
  assign dbg_state      = state;

endmodule

// File: tb/tb_uart_report_tx.sv
// Bench for uart_report_tx. Two instances: dut_a with the periodic timer
// off, dut_b with a 2000-cycle period. Only one is out of reset at a time;
// sel picks which one the line model follows.
module tb_uart_report_tx;

  localparam int BD = 10;   // 1 MHz / 100 kbaud

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sel;
  logic [7:0]  mod_type;
  logic [15:0] demod_fre;
  logic        send_req;

  uart_report_tx_if if_a ();
  uart_report_tx_if if_b ();
  uart_report_pkg::rpt_state_e dbg_a, dbg_b;

  assign if_a.mod_type  = mod_type;
  assign if_a.demod_fre = demod_fre;
  assign if_a.send_req  = send_req;
  assign if_b.mod_type  = mod_type;
  assign if_b.demod_fre = demod_fre;
  assign if_b.send_req  = send_req;

  uart_report_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .REPORT_CYCLES(0)) dut_a (
    .sys_clk (clk), .sys_rst_n (rst_a), .rpt (if_a), .dbg_state (dbg_a));

  uart_report_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .REPORT_CYCLES(2000)) dut_b (
    .sys_clk (clk), .sys_rst_n (rst_b), .rpt (if_b), .dbg_state (dbg_b));

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_fd_a = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Frame contents straight from the packet definition.
  function automatic logic [7:0] mdl_byte(input int i, input logic [7:0] m, input logic [15:0] f);
    logic [15:0] ff;
    logic [7:0]  b [6];
    ff   = (m == 8'd0 || m == 8'd6) ? 16'h0000 : f;
    b[0] = 8'hA5;
    b[1] = m;
    b[2] = ff[15:8];
    b[3] = ff[7:0];
    b[4] = m + ff[15:8] + ff[7:0];
    b[5] = 8'h5A;
    return b[i];
  endfunction

  // Expected {tx, busy, frame_done} per cycle, oldest first.
  logic [2:0] exp_q[$];
  logic [2:0] exp_now = 3'b100;
  bit         m_pend = 1'b0;
  int         m_timer = 0;

  task automatic push_frame(input logic [7:0] m, input logic [15:0] f);
    logic [7:0] by;
    logic       bitv;
    for (int i = 0; i < 6; i++) begin
      by = mdl_byte(i, m, f);
      for (int s = 0; s < 10; s++) begin
        bitv = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : by[s-1];
        for (int c = 0; c < BD; c++) exp_q.push_back({bitv, 1'b1, 1'b0});
      end
    end
    exp_q.push_back(3'b101);
  endtask

  // Line model: decides at each edge what the next cycle must look like.
  always @(posedge clk) begin
    logic rst_s;
    int   rc;
    bit   req;
    rst_s = sel ? rst_b : rst_a;
    rc    = sel ? 2000 : 0;
    if (!rst_s) begin
      exp_q.delete();
      m_pend  = 1'b0;
      m_timer = 0;
      exp_now = 3'b100;
    end else begin
      req = send_req || (rc > 0 && m_timer == rc - 1);
      if (rc > 0) m_timer = (m_timer == rc - 1) ? 0 : m_timer + 1;
      if (exp_q.size() == 0 && m_pend) begin
        push_frame(mod_type, demod_fre);
        m_pend = 1'b0;
      end
      m_pend = m_pend || req;
      if (exp_q.size() == 0) exp_q.push_back(3'b100);
      exp_now = exp_q.pop_front();
    end
  end

  // Compare process.
  always @(negedge clk) begin
    logic [2:0] act;
    logic       rst_s;
    act   = sel ? {if_b.tx, if_b.busy, if_b.frame_done} : {if_a.tx, if_a.busy, if_a.frame_done};
    rst_s = sel ? rst_b : rst_a;
    chk("line", {29'd0, act}, {29'd0, rst_s ? exp_now : 3'b100});
    if (!sel && if_a.frame_done) n_fd_a++;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_req();
    @(negedge clk);
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
  endtask

  task automatic wait_done(output int busy_cnt);
    busy_cnt = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (sel ? if_b.busy : if_a.busy) busy_cnt++;
      if (sel ? if_b.frame_done : if_a.frame_done) return;
    end
    chk("frame_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] lit [0:17];
  int         n;

  initial begin
    sel       = 1'b0;
    rst_a     = 1'b0;
    rst_b     = 1'b0;
    send_req  = 1'b0;
    mod_type  = 8'd0;
    demod_fre = 16'd0;

    // Hand-computed frames pin the model.
    lit = '{8'hA5, 8'h03, 8'h07, 8'hD0, 8'hDA, 8'h5A,
            8'hA5, 8'h06, 8'h00, 8'h00, 8'h06, 8'h5A,
            8'hA5, 8'h01, 8'h03, 8'hE8, 8'hEC, 8'h5A};
    for (int i = 0; i < 6; i++) begin
      chk("pin_fm",  {24'd0, mdl_byte(i, 8'd3, 16'h07D0)}, {24'd0, lit[i]});
      chk("pin_cw",  {24'd0, mdl_byte(i, 8'd6, 16'h1234)}, {24'd0, lit[6+i]});
      chk("pin_am",  {24'd0, mdl_byte(i, 8'd1, 16'h03E8)}, {24'd0, lit[12+i]});
    end

    // 1: reset, then idle
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    repeat (200) @(negedge clk);
    chk("idle_tx", {31'd0, if_a.tx}, 32'd1);
    chk("idle_busy", {31'd0, if_a.busy}, 32'd0);
    chk("idle_no_frames", n_fd_a, 32'd0);

    // 2: FM frame
    mod_type = 8'd3; demod_fre = 16'h07D0;
    pulse_req();
    wait_done(n);
    chk("busy_len_fm", n, 32'd600);
    repeat (20) @(negedge clk);

    // 3: CW frame, frequency forced to zero
    mod_type = 8'd6; demod_fre = 16'h1234;
    pulse_req();
    wait_done(n);
    chk("busy_len_cw", n, 32'd600);
    repeat (20) @(negedge clk);

    // 4: inputs change mid-frame
    mod_type = 8'd1; demod_fre = 16'h03E8;
    pulse_req();
    repeat (100) @(negedge clk);
    mod_type = 8'd5; demod_fre = 16'hFFFF;
    wait_done(n);
    repeat (20) @(negedge clk);

    // 5: three requests during a frame coalesce into one follow-up
    mod_type = 8'd4; demod_fre = 16'h2710;
    pulse_req();
    repeat (50) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pulse_req();
      repeat (30) @(negedge clk);
    end
    wait_done(n);
    @(negedge clk);
    chk("gap_tx", {31'd0, if_a.tx}, 32'd0);
    chk("gap_busy", {31'd0, if_a.busy}, 32'd1);
    wait_done(n);
    repeat (200) @(negedge clk);

    // 5b: request held into the launch cycle yields exactly one follow-up
    mod_type = 8'd2; demod_fre = 16'h0BB8;
    @(negedge clk);
    send_req = 1'b1;
    repeat (2) @(negedge clk);
    send_req = 1'b0;
    wait_done(n);
    wait_done(n);
    repeat (100) @(negedge clk);
    chk("frame_count_a", n_fd_a, 32'd7);

    // 6: periodic timer and reset mid-frame
    rst_a = 1'b0;
    sel   = 1'b1;
    mod_type = 8'd3; demod_fre = 16'h07D0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    n = 0;
    while (!if_b.busy && n < 5000) begin @(negedge clk); n++; end
    chk("first_period", n, 32'd2001);
    repeat (150) @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("rst_tx", {31'd0, if_b.tx}, 32'd1);
    chk("rst_busy", {31'd0, if_b.busy}, 32'd0);
    repeat (4) @(negedge clk);
    rst_b = 1'b1;
    n = 0;
    while (!if_b.busy && n < 5000) begin @(negedge clk); n++; end
    chk("period_after_rst", n, 32'd2001);
    n = 0;
    while (if_b.busy && n < 5000) begin @(negedge clk); n++; end
    while (!if_b.busy && n < 5000) begin @(negedge clk); n++; end
    chk("period", n, 32'd2000);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
